light_show_sequencer: RTL
=========================

// Module: light_show_sequencer
// PURPOSE
//  Autonomous controller for the lights selector datapath. Drives its sel and button
//  inputs so that a white phase is followed by an automatic walk through NUM_STEPS
//  colours of the LED colour counter.
//  A manual override lets a user drive sel/button directly, with the show paused.
//  Sits between top-level switches/buttons and the lights selector; light itself is untouched.
// PARAMETERS
//  WHITE_CYCLES  16  cycles spent in the white phase (sel=0) before colour stepping; >=1
//  STEP_CYCLES   8   dwell cycles per colour step (sel=1); >=1
//  NUM_STEPS     6   button pulses (colour advances) per show; 1..7
//  CW            8   internal dwell counter width; must hold max(WHITE_CYCLES,STEP_CYCLES)-1
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  rst            in   1  synchronous, active-high reset
//  start          in   1  begin a show; sampled only in IDLE
//  stop           in   1  abort show, return to IDLE; priority over all other inputs
//  repeat_en      in   1  level; at end of show restart at WHITE instead of IDLE
//  manual         in   1  level; override active, FSM frozen
//  manual_sel     in   1  sel value driven while manual=1
//  manual_button  in   1  raw level button, rising edge used while manual=1
//  sel            out  1  to lights selector: 0=white, 1=RGB colour
//  button         out  1  to LED colour counter: single-cycle advance pulse
//  active         out  1  high while a show is running (WHITE or STEP), incl. while paused
//  step_count     out  3  number of auto pulses issued in current show
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, sel=0, button=0, active=0,
//    step_count=0, dwell counter=0, manual_button edge register=0.
//  - States: IDLE, WHITE, STEP.
//  - IDLE: sel=0, active=0. start=1 (and stop=0) -> WHITE next cycle, counter=0,
//    step_count=0.
//  - WHITE: sel=0, active=1. Counter increments. After WHITE_CYCLES cycles -> STEP.
//    First STEP cycle has sel=1, button=1, step_count+1.
//  - STEP: sel=1. After STEP_CYCLES dwell cycles:
//    - if step_count<NUM_STEPS: stay in STEP, pulse button, step_count+1, counter=0.
//    - else (final dwell done): repeat_en=1 -> WHITE (step_count=0); else -> IDLE
//      (sel=0, active=0).
//  - button is high for exactly one cycle per pulse, never two consecutive cycles.
//  - Latency: start at cycle t -> active=1 at t+1; first pulse at t+1+WHITE_CYCLES.
//  - stop=1: next cycle IDLE, sel=0, button=0, active=0, step_count=0, counter=0.
//    This applies in any state, including during manual. stop wins over start in
//    the same cycle.
//  - start while not IDLE is ignored; it does not restart the show.
//  - manual=1: state, counter and step_count hold. sel=manual_sel (1-cycle latency).
//    button=registered rising edge of manual_button (1-cycle latency).
//    Manual pulses do not change step_count.
//  - manual_button edge register updates every cycle regardless of manual, so
//    asserting manual with the button already held gives no pulse.
//  - manual 1->0: FSM resumes from the frozen counter value; sel reverts to the
//    state value next cycle. No pulse is generated on the transition.
//  - rst mid-show: identical to the reset values above. rst has priority over stop.
// TESTING
//  1 rst, then start pulse at cycle 0, repeat_en=0 -> active=1 @1; button pulses
//    @17,25,33,41,49,57; sel=1 @17..64; IDLE/sel=0/active=0 @65; step_count=6 @57.
//  2 as 1 with repeat_en=1 -> WHITE @65 (sel=0, step_count=0), next pulse @81.
//  3 stop=1 @30 -> @31 sel=0, active=0, step_count=0; no further pulses.
//    start+stop same cycle from IDLE -> stays IDLE.
//  4 manual=1 @20..39, manual_sel=0, manual_button rising @25 -> sel=0 @21..40,
//    button @26 only, step_count stays 1; auto pulses resume at 25+20=45.
//  5 start pulsed again @10 and @20 during a show -> pulse schedule identical to test 1.
//  6 rst=1 @40 mid-STEP -> @41 all outputs at reset values; manual_button held high
//    through manual rise gives no pulse.

Source files
------------

// File: rtl/light_show_sequencer.sv
// Light show sequencer: white phase, then an automatic walk through NUM_STEPS colours, with a manual override.
// Latency: every output is registered, so an input sampled in cycle t shows up at t+1; the first colour pulse comes WHITE_CYCLES cycles after active rises.
// Backpressure: none; start is a pulse, repeat_en and manual are levels, stop wins over all of them, and rst wins over stop.
module light_show_sequencer #(
    parameter int WHITE_CYCLES = 16,
    parameter int STEP_CYCLES  = 8,
    parameter int NUM_STEPS    = 6,
    parameter int CW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       repeat_en,
    input  logic       manual,
    input  logic       manual_sel,
    input  logic       manual_button,
    output logic       sel,
    output logic       button,
    output logic       active,
    output logic [2:0] step_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WHITE = 2'd1,
        STEP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] WHITE_LAST = CW'(WHITE_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [2:0]    STEPS_MAX  = 3'(NUM_STEPS);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    sc_nxt;
    logic          sel_nxt, button_nxt, active_nxt;
    logic          btn_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sc_nxt     = step_count;
        button_nxt = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sc_nxt    = '0;
        end else if (manual) begin
            // FSM frozen; only the user's button edge reaches the colour counter
            button_nxt = manual_button & ~btn_q;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = WHITE;
                        cnt_nxt   = '0;
                        sc_nxt    = '0;
                    end
                end
                WHITE: begin
                    if (cnt == WHITE_LAST) begin
                        state_nxt  = STEP;
                        cnt_nxt    = '0;
                        button_nxt = 1'b1;
                        sc_nxt     = step_count + 3'd1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STEP: begin
                    if (cnt != STEP_LAST) begin
                        cnt_nxt = cnt + 1'b1;
                    end else if (step_count < STEPS_MAX) begin
                        cnt_nxt    = '0;
                        button_nxt = 1'b1;
                        sc_nxt     = step_count + 3'd1;
                    end else if (repeat_en) begin
                        state_nxt = WHITE;
                        cnt_nxt   = '0;
                        sc_nxt    = '0;
                    end else begin
                        // step_count keeps the finished show's total until the next start
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sc_nxt    = '0;
                end
            endcase
        end
        active_nxt = (state_nxt != IDLE);
        if (stop) begin
            sel_nxt = 1'b0;
        end else if (manual) begin
            sel_nxt = manual_sel;
        end else begin
            sel_nxt = (state_nxt == STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            step_count <= '0;
            sel        <= 1'b0;
            button     <= 1'b0;
            active     <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            step_count <= sc_nxt;
            sel        <= sel_nxt;
            button     <= button_nxt;
            active     <= active_nxt;
            // tracked even outside manual so an already-held button gives no edge
            btn_q      <= manual_button;
        end
    end

endmodule
